bcd_binario: RTL and testbench

Sequential BCD-to-binary converter: takes a three-digit BCD number (hundreds, tens, units) and produces its binary value.
Inverse of the team's binary-to-BCD path; used wherever keypad/display-side decimal digits must return to the datapath as binary.
Horner evaluation, one digit per clock (acc = acc*10 + digit), with a start/busy/done handshake.
Detects invalid BCD digits (>9).

---
 rtl/bcd_binario_pkg.sv | 27 ++
 rtl/bcd_binario_mul10_add.sv | 31 +++
 rtl/bcd_binario.sv | 143 ++++++++++++++
 tb/tb_bcd_binario.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_binario_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared definitions for the BCD-to-binary converter: FSM state
//               encoding, digit constants and a BCD digit validity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int BCD_DIGIT_W  = 4;
  localparam int BCD_MAX      = 9;
  localparam int BCD_N_DIGITS = 3;
  localparam int SAT8_MAX     = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd_state_t;

  // A BCD digit is invalid when its 4-bit code exceeds 9 (codes A..F).
  function automatic logic bcd_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(BCD_MAX);
  endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_binario_mul10_add.sv
`default_nettype none
// ============================================================================
// Module      : mul10_add
// Description : Combinational Horner step: result = acc*10 + digit, built from
//               shifts and adds only ((acc<<3) + (acc<<1) + digit).
// Ports       : acc    [BIN_W-1:0]  running accumulator
//               digit  [3:0]        next BCD digit
//               result [BIN_W-1:0]  acc*10 + digit (wraps modulo 2**BIN_W)
// Revision    : 1.0 - initial release
// ============================================================================
module mul10_add
  import bcd_pkg::*;
#(
  parameter int BIN_W = 10
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       result
);

  logic [BIN_W-1:0] acc_x8;
  logic [BIN_W-1:0] acc_x2;
  logic [BIN_W-1:0] digit_ext;

  assign acc_x8    = acc << 3;
  assign acc_x2    = acc << 1;
  assign digit_ext = {{(BIN_W-BCD_DIGIT_W){1'b0}}, digit};
  assign result    = acc_x8 + acc_x2 + digit_ext;

endmodule : mul10_add
`default_nettype wire

// File: rtl/bcd_binario.sv
`default_nettype none
// ============================================================================
// Module      : bcd_binario
// Description : Sequential three-digit BCD-to-binary converter. Horner
//               evaluation one digit per clock (acc = acc*10 + digit) with a
//               start/busy/done handshake and invalid-digit detection.
// Ports       : clk, reset (sync, active-high)
//               start, centena, decena, unidad   request + digits (IDLE only)
//               busy      high from cycle after accept through DONE cycle
//               done      one-cycle pulse, results valid
//               binario   converted value, held until next completion
//               error     any latched digit > 9 (binario forced to 0)
//               desborde  saturation flag
// Options     : BCD_BINARIO_SAT8_EN - clamp valid results above 255 to 255
//               and raise desborde; when undefined desborde is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_binario
  import bcd_pkg::*;
#(
  parameter int BIN_W = 10   // must be >= 10 so that 999 fits
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BCD_DIGIT_W-1:0] centena,
  input  logic [BCD_DIGIT_W-1:0] decena,
  input  logic [BCD_DIGIT_W-1:0] unidad,
  output logic                   busy,
  output logic                   done,
  output logic [BIN_W-1:0]       binario,
  output logic                   error,
  output logic                   desborde
);

  bcd_state_t             state;
  logic [BCD_DIGIT_W-1:0] dig_c;
  logic [BCD_DIGIT_W-1:0] dig_d;
  logic [BCD_DIGIT_W-1:0] dig_u;
  logic [BIN_W-1:0]       acc;
  logic [1:0]             cnt;

  logic [BCD_DIGIT_W-1:0] cur_digit;
  logic [BIN_W-1:0]       acc_next;
  logic                   any_invalid;
  logic                   last_step;

  // Digits are consumed most-significant first.
  always_comb begin
    cur_digit = dig_u;
    case (cnt)
      2'd0:    cur_digit = dig_c;
      2'd1:    cur_digit = dig_d;
      default: cur_digit = dig_u;
    endcase
  end

  assign any_invalid = bcd_invalid(dig_c) | bcd_invalid(dig_d) | bcd_invalid(dig_u);
  assign last_step   = (cnt == 2'(BCD_N_DIGITS - 1));

  mul10_add #(
    .BIN_W (BIN_W)
  ) u_mul10_add (
    .acc    (acc),
    .digit  (cur_digit),
    .result (acc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      binario <= '0;
      error   <= 1'b0;
      dig_c   <= '0;
      dig_d   <= '0;
      dig_u   <= '0;
      acc     <= '0;
      cnt     <= 2'd0;
`ifdef BCD_BINARIO_SAT8_EN
      desborde <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dig_c <= centena;
            dig_d <= decena;
            dig_u <= unidad;
            acc   <= '0;
            cnt   <= 2'd0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end

        CONV: begin
          acc <= acc_next;
          cnt <= cnt + 2'd1;
          if (last_step) begin
            done  <= 1'b1;
            state <= DONE;
            error <= any_invalid;
`ifdef BCD_BINARIO_SAT8_EN
            // Invalid input takes priority over saturation.
            if (any_invalid) begin
              binario  <= '0;
              desborde <= 1'b0;
            end else if (acc_next > BIN_W'(SAT8_MAX)) begin
              binario  <= BIN_W'(SAT8_MAX);
              desborde <= 1'b1;
            end else begin
              binario  <= acc_next;
              desborde <= 1'b0;
            end
`else
            binario <= any_invalid ? '0 : acc_next;
`endif
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef BCD_BINARIO_SAT8_EN
  assign desborde = 1'b0;
`endif

endmodule : bcd_binario
`default_nettype wire

// File: tb/tb_bcd_binario.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_binario
// Description : Directed self-checking bench for bcd_binario. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Options     : BCD_BINARIO_SAT8_EN - expected values follow the 8-bit
//               saturating variant when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_binario;

  localparam int BIN_W = 10;

  logic             clk;
  logic             reset;
  logic             start;
  logic [3:0]       centena;
  logic [3:0]       decena;
  logic [3:0]       unidad;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] binario;
  logic             error;
  logic             desborde;

  int checks;
  int failures;
  int done_total;
  int start_total;

  bcd_binario #(
    .BIN_W (BIN_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .centena  (centena),
    .decena   (decena),
    .unidad   (unidad),
    .busy     (busy),
    .done     (done),
    .binario  (binario),
    .error    (error),
    .desborde (desborde)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_total++;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Expected binario/desborde for a valid decimal value.
  function automatic logic [31:0] exp_bin(input int v);
`ifdef BCD_BINARIO_SAT8_EN
    return (v > 255) ? 32'd255 : 32'(v);
`else
    return 32'(v);
`endif
  endfunction

  function automatic logic [31:0] exp_des(input int v);
`ifdef BCD_BINARIO_SAT8_EN
    return (v > 255) ? 32'd1 : 32'd0;
`else
    if (v < 0) return 32'd1;
    return 32'd0;
`endif
  endfunction

  // Issues one conversion and follows it for five edges: busy must be high
  // after edges k..k+3, done only after k+3, and everything idle after k+4.
  // Returns on the falling edge after k+4, where the next start may be set.
  task automatic run_conv(input logic [3:0] c, input logic [3:0] d,
                          input logic [3:0] u, input logic [31:0] e_bin,
                          input logic [31:0] e_err, input logic [31:0] e_des);
    int busy_cnt;
    int done_cnt;
    int done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    centena  = c;
    decena   = d;
    unidad   = u;
    start    = 1'b1;
    start_total++;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
        check("binario", 32'(binario), e_bin);
        check("error", 32'(error), e_err);
        check("desborde", 32'(desborde), e_des);
      end
    end
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_latency", 32'(done_at), 32'd3);
    check("busy_cycles", 32'(busy_cnt), 32'd4);
  endtask

  initial begin
    int n_done;
    checks      = 0;
    failures    = 0;
    done_total  = 0;
    start_total = 0;
    reset   = 1'b1;
    start   = 1'b0;
    centena = 4'd0;
    decena  = 4'd0;
    unidad  = 4'd0;

    // Reset for two cycles.
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_binario", 32'(binario), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_desborde", 32'(desborde), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors.
    run_conv(4'd2, 4'd5, 4'd5, 32'd255, 32'd0, 32'd0);
    run_conv(4'd9, 4'd9, 4'd9, exp_bin(999), 32'd0, exp_des(999));
    run_conv(4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    run_conv(4'hA, 4'd0, 4'd3, 32'd0, 32'd1, 32'd0);
    run_conv(4'd1, 4'd2, 4'd8, 32'd128, 32'd0, 32'd0);
    run_conv(4'd3, 4'hF, 4'd1, 32'd0, 32'd1, 32'd0);
    run_conv(4'd2, 4'd5, 4'd6, exp_bin(256), 32'd0, exp_des(256));
    run_conv(4'd0, 4'd0, 4'hC, 32'd0, 32'd1, 32'd0);

    // A second start one cycle into the conversion must be ignored, and the
    // digit change after the latch edge must have no effect.
    centena = 4'd1;
    decena  = 4'd0;
    unidad  = 4'd0;
    start   = 1'b1;
    start_total++;
    @(negedge clk);
    centena = 4'd7;
    decena  = 4'd7;
    unidad  = 4'd7;
    @(negedge clk);
    start  = 1'b0;
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        n_done++;
        check("ign_binario", 32'(binario), 32'd100);
        check("ign_error", 32'(error), 32'd0);
      end
      @(negedge clk);
    end
    check("ign_done_count", 32'(n_done), 32'd1);

    // Reset in the CONV cycle following the first accumulation step.
    centena = 4'd4;
    decena  = 4'd5;
    unidad  = 4'd6;
    start   = 1'b1;
    @(negedge clk);           // past start edge k
    start = 1'b0;
    @(negedge clk);           // past k+1, first accumulation done
    reset = 1'b1;
    @(negedge clk);           // past k+2, reset taken
    reset  = 1'b0;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("abort_done_count", 32'(n_done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_binario", 32'(binario), 32'd0);
    check("abort_error", 32'(error), 32'd0);
    check("abort_desborde", 32'(desborde), 32'd0);
    run_conv(4'd4, 4'd5, 4'd6, exp_bin(456), 32'd0, exp_des(456));

    // Back-to-back sweep of every valid three-digit value.
    for (int c = 0; c < 10; c++) begin
      for (int d = 0; d < 10; d++) begin
        for (int u = 0; u < 10; u++) begin
          run_conv(4'(c), 4'(d), 4'(u), exp_bin(100*c + 10*d + u), 32'd0,
                   exp_des(100*c + 10*d + u));
        end
      end
    end

    repeat (3) @(negedge clk);
    check("done_vs_start", 32'(done_total), 32'(start_total));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bcd_binario
`default_nettype wire
